// File: rtl/bus_pkg.sv
// Shared bus command encodings and fetcher state type.
package bus_pkg;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        DONE
    } fetch_state_e;

endpackage

// File: rtl/mem_load_fetcher_if.sv
// Memory bus plus downstream valid/ready stream for the load fetcher.
interface mem_load_fetcher_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    logic                  store_pending;
    logic [3:0]            mem2proc_response;
    logic [3:0]            mem2proc_tag;
    logic [DATA_WIDTH-1:0] mem2proc_data;
    logic [1:0]            proc2mem_command;
    logic [ADDR_WIDTH-1:0] proc2mem_address;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    // Fetcher side: drives the bus command and the stream head.
    modport master (
        input  store_pending, mem2proc_response, mem2proc_tag, mem2proc_data, out_ready,
        output proc2mem_command, proc2mem_address, out_valid, out_data
    );

    // Memory / consumer side.
    modport slave (
        output store_pending, mem2proc_response, mem2proc_tag, mem2proc_data, out_ready,
        input  proc2mem_command, proc2mem_address, out_valid, out_data
    );
endinterface

// File: rtl/load_data_fifo.sv
// Small synchronous FIFO holding returned load data; head is readable without latency.
module load_data_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;
    localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;

    // Pointer and occupancy update; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset empties the buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    // Overflow and underflow are excluded by the caller's issue gating.
    always_ff @(posedge clock) begin
        if (reset) begin
            assert (!(push && !pop && (count_q == CNT_FULL)));
            assert (!(pop && (count_q == '0)));
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/mem_load_fetcher.sv
// Sweeps an address range issuing one load at a time and streams the returned data.
module mem_load_fetcher
    import bus_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    ADDR_WIDTH  = 64,
    parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0,
    parameter logic [ADDR_WIDTH-1:0] LIMIT_ADDR  = 'h10000,
    parameter int                    FIFO_DEPTH  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    mem_load_fetcher_if.master  bus,
    output logic                busy,
    output logic                done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FIFO_FULL = FIFO_DEPTH[CW-1:0];

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            held_tag_q, held_tag_d;
    logic [ADDR_WIDTH:0]   addr_inc;
    logic                  issue_ok;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [CW-1:0]         fifo_count;

    // One extra bit so the limit test never sees a wrapped address.
    assign addr_inc = {1'b0, addr_q} + {1'b0, ADDR_STRIDE};
    // Only request when the store side is quiet and a FIFO slot is free for the reply.
    assign issue_ok = (state_q == ISSUE) && !bus.store_pending && (fifo_count < FIFO_FULL);

    // Next-state, bus command and status outputs.
    always_comb begin
        state_d              = state_q;
        addr_d               = addr_q;
        held_tag_d           = held_tag_q;
        fifo_push            = 1'b0;
        bus.proc2mem_command = issue_ok ? BUS_LOAD : BUS_NONE;
        bus.proc2mem_address = issue_ok ? addr_q : '0;
        busy                 = (state_q != IDLE) && (state_q != DONE);
        done                 = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = BASE_ADDR;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A zero response is a refusal; stay and retry.
                if (issue_ok && (bus.mem2proc_response != 4'd0)) begin
                    held_tag_d = bus.mem2proc_response;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // Tags belonging to other traffic are ignored.
                if ((bus.mem2proc_tag != 4'd0) && (bus.mem2proc_tag == held_tag_q)) begin
                    fifo_push = 1'b1;
                    addr_d    = addr_inc[ADDR_WIDTH-1:0];
                    state_d   = (addr_inc >= {1'b0, LIMIT_ADDR}) ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                if (fifo_count == '0) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    addr_d  = BASE_ADDR;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any outstanding tag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= BASE_ADDR;
            held_tag_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            held_tag_q <= held_tag_d;
        end
    end

    assign bus.out_valid = (fifo_count != '0);
    assign fifo_pop      = bus.out_valid && bus.out_ready;

    load_data_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus.mem2proc_data),
        .pop       (fifo_pop),
        .head_data (bus.out_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mem_load_fetcher.sv
// Directed bench for mem_load_fetcher with a data scoreboard on the output stream.
module tb_mem_load_fetcher;
    import bus_pkg::*;

    // Eight-word range: long enough to exercise FIFO back-pressure before the sweep ends.
    localparam logic [63:0] LIMIT = 64'h20;

    logic clock = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q [$];

    mem_load_fetcher_if bus ();

    mem_load_fetcher #(
        .DATA_WIDTH  (64),
        .ADDR_WIDTH  (64),
        .ADDR_STRIDE (64'd4),
        .BASE_ADDR   (64'h0),
        .LIMIT_ADDR  (LIMIT),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Output side of the scoreboard: every accepted beat must match the oldest expectation.
    always @(negedge clock) begin
        #2;
        if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL pop_unexpected observed=%0h expected=none", bus.out_data);
            end else begin
                chk("pop_data", bus.out_data, exp_q.pop_front());
            end
        end
    end

    // Memory model for one load: accept with tag, optional foreign tag, then return data.
    task automatic do_load(input logic [3:0] tag, input logic [63:0] data,
                           input logic [63:0] exp_addr, input int lat);
        int n;
        logic [3:0] other;
        n = 0;
        other = (tag == 4'hF) ? 4'hE : 4'hF;
        #1;
        while (bus.proc2mem_command !== BUS_LOAD && n < 40) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("load_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_LOAD});
        chk("load_addr", bus.proc2mem_address, exp_addr);
        bus.mem2proc_response = tag;
        @(negedge clock);
        bus.mem2proc_response = 4'd0;
        for (int i = 0; i < lat; i++) begin
            bus.mem2proc_tag  = (i == 0) ? other : 4'd0;
            bus.mem2proc_data = 64'hBAD0_BAD0_BAD0_BAD0;
            @(negedge clock);
        end
        bus.mem2proc_tag  = tag;
        bus.mem2proc_data = data;
        exp_q.push_back(data);
        @(negedge clock);
        bus.mem2proc_tag  = 4'd0;
        bus.mem2proc_data = 64'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        reset                 = 1'b0;
        start                 = 1'b1;
        bus.store_pending     = 1'b0;
        bus.mem2proc_response = 4'd0;
        bus.mem2proc_tag      = 4'd0;
        bus.mem2proc_data     = 64'd0;
        bus.out_ready         = 1'b0;

        // Reset held with start asserted
        repeat (2) @(negedge clock);
        #1;
        chk("rst_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_NONE});
        chk("rst_addr", bus.proc2mem_address, 64'd0);
        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        #1;
        chk("t1_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_NONE});
        chk("t1_addr", bus.proc2mem_address, 64'd0);
        chk("t1_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t1_done", {63'd0, done}, 64'd0);
        chk("t1_busy", {63'd0, busy}, 64'd0);

        // First load, data visible the cycle after the tag match
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        chk("t2_busy", {63'd0, busy}, 64'd1);
        do_load(4'd3, 64'h0000_0005_0000_0007, 64'h0, 1);
        #1;
        chk("t2_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("t2_data", bus.out_data, 64'h0000_0005_0000_0007);
        chk("t2_next_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_LOAD});
        chk("t2_next_addr", bus.proc2mem_address, 64'h4);

        // Store side owns the bus for three cycles; a stray response is ignored
        bus.store_pending = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_NONE});
            chk("t3_addr", bus.proc2mem_address, 64'h0);
            if (i == 1) bus.mem2proc_response = 4'd5;
            @(negedge clock);
            bus.mem2proc_response = 4'd0;
        end
        bus.store_pending = 1'b0;
        #1;
        chk("t3_resume_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_LOAD});
        chk("t3_resume_addr", bus.proc2mem_address, 64'h4);
        chk("t3_head_stable", bus.out_data, 64'h0000_0005_0000_0007);

        // Back-pressure: four entries fill the FIFO and issuing stops
        do_load(4'd1, 64'h0000_0000_0000_00A1, 64'h4, 0);
        do_load(4'd2, 64'h0000_0000_0000_00A2, 64'h8, 2);
        do_load(4'd4, 64'h0000_0000_0000_00A3, 64'hC, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_full_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_NONE});
            chk("t4_full_busy", {63'd0, busy}, 64'd1);
            chk("t4_full_head", bus.out_data, 64'h0000_0005_0000_0007);
            @(negedge clock);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t4_still_full", {62'd0, bus.proc2mem_command}, {62'd0, BUS_NONE});
        @(negedge clock);
        #1;
        chk("t4_resume_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_LOAD});
        chk("t4_resume_addr", bus.proc2mem_address, 64'h10);

        // Finish the sweep and drain
        do_load(4'd6, 64'h1111_2222_3333_4444, 64'h10, 0);
        do_load(4'd7, 64'hDEAD_BEEF_0000_0001, 64'h14, 3);
        do_load(4'd8, 64'h8000_0000_0000_0008, 64'h18, 1);
        do_load(4'd9, 64'h0123_4567_89AB_CDEF, 64'h1C, 2);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            #1;
            if (bus.proc2mem_command !== BUS_NONE)
                chk("t5_no_extra_load", {62'd0, bus.proc2mem_command}, {62'd0, BUS_NONE});
            @(negedge clock);
            n++;
        end
        #1;
        chk("t5_done", {63'd0, done}, 64'd1);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            chk("t5_idle_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_NONE});
            chk("t5_done_hold", {63'd0, done}, 64'd1);
        end

        // Restart from DONE goes back to the base address
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        chk("t5_restart_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_LOAD});
        chk("t5_restart_addr", bus.proc2mem_address, 64'h0);
        chk("t5_restart_done", {63'd0, done}, 64'd0);

        // Reset while waiting for a tag; the late tag must not be captured
        bus.out_ready = 1'b0;
        do_load(4'd5, 64'h0000_0000_0000_CAFE, 64'h0, 0);
        #1;
        chk("t6_valid_pre", {63'd0, bus.out_valid}, 64'd1);
        #1;
        chk("t6_issue_addr", bus.proc2mem_address, 64'h4);
        bus.mem2proc_response = 4'd6;
        @(negedge clock);
        bus.mem2proc_response = 4'd0;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_NONE});
        @(negedge clock);
        reset             = 1'b1;
        bus.mem2proc_tag  = 4'd6;
        bus.mem2proc_data = 64'h0000_0000_0000_0BAD;
        @(negedge clock);
        bus.mem2proc_tag  = 4'd0;
        bus.mem2proc_data = 64'd0;
        #1;
        chk("t6_late_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_late_busy", {63'd0, busy}, 64'd0);
        chk("t6_late_done", {63'd0, done}, 64'd0);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        chk("t6_restart_cmd", {62'd0, bus.proc2mem_command}, {62'd0, BUS_LOAD});
        chk("t6_restart_addr", bus.proc2mem_address, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
